// File: rtl/ts4231_bmc_decoder.sv
// Biphase-mark decoder for the TS4231 light-sensor data line: measures the spacing
// between data-line transitions inside an envelope and assembles NBITS-bit words.
module ts4231_bmc_decoder #(
    parameter int HALF_MIN = 4,
    parameter int HALF_MAX = 11,
    parameter int FULL_MAX = 23,
    parameter int NBITS    = 17
) (
    input  logic             clk_96MHz,
    input  logic             reset,
    input  logic             e_in_r,
    input  logic             d_in_r,
    input  logic [23:0]      system_timestamp,
    output logic             data_availible,
    output logic [NBITS-1:0] decoded_data,
    output logic [23:0]      timestamp_last_data,
    output logic             decode_error
);

    localparam int CW = $clog2(NBITS + 1);
    localparam logic [4:0]    HALF_MIN_C = 5'(HALF_MIN);
    localparam logic [4:0]    HALF_MAX_C = 5'(HALF_MAX);
    localparam logic [4:0]    FULL_MAX_C = 5'(FULL_MAX);
    localparam logic [CW-1:0] LAST_BIT_C = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        DECODE,
        WAIT_END
    } state_t;

    state_t           state_q, state_d;
    logic             d_prev_q;
    logic             e_prev_q;
    logic [23:0]      ts_cap_q, ts_cap_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             half_q, half_d;
    logic [4:0]       ivl_q, ivl_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic [23:0]      ts_out_q, ts_out_d;
    logic             avail_q, avail_d;
    logic             err_q, err_d;

    logic             trans;
    logic             env_start;
    logic             env_end;
    logic             is_half;
    logic             is_full;
    logic             got_bit;
    logic             new_bit;
    logic             bad_ivl;
    logic [NBITS-1:0] shifted;

    assign trans     = d_in_r ^ d_prev_q;
    assign env_start = e_prev_q & ~e_in_r;
    assign env_end   = e_in_r;
    assign is_half   = (ivl_q >= HALF_MIN_C) && (ivl_q <= HALF_MAX_C);
    assign is_full   = (ivl_q > HALF_MAX_C) && (ivl_q <= FULL_MAX_C);

    always_comb begin
        state_d   = state_q;
        ts_cap_d  = ts_cap_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        half_d    = half_q;
        ivl_d     = ivl_q;
        dout_d    = dout_q;
        ts_out_d  = ts_out_q;
        avail_d   = 1'b0;
        err_d     = 1'b0;
        got_bit   = 1'b0;
        new_bit   = 1'b0;
        bad_ivl   = 1'b0;
        shifted   = shift_q;

        case (state_q)
            IDLE: begin
                if (env_start) begin
                    ts_cap_d  = system_timestamp;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    half_d    = 1'b0;
                    state_d   = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (env_end) begin
                    state_d = IDLE;
                end else if (trans) begin
                    ivl_d   = 5'd1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ivl_d = trans ? 5'd1 : ((ivl_q == 5'd31) ? ivl_q : ivl_q + 5'd1);
                if (trans) begin
                    if (is_half && !half_q) begin
                        half_d = 1'b1;
                    end else if (is_half && half_q) begin
                        got_bit = 1'b1;
                        new_bit = 1'b1;
                        half_d  = 1'b0;
                    end else if (is_full && !half_q) begin
                        got_bit = 1'b1;
                    end else begin
                        bad_ivl = 1'b1;
                    end
                end
                shifted = {shift_q[NBITS-2:0], new_bit};
                if (got_bit) begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // Completing the word wins over a simultaneous envelope end.
                if (got_bit && (bit_cnt_q == LAST_BIT_C)) begin
                    dout_d   = shifted;
                    ts_out_d = ts_cap_q;
                    avail_d  = 1'b1;
                    state_d  = env_end ? IDLE : WAIT_END;
                end else if (bad_ivl) begin
                    err_d   = 1'b1;
                    state_d = env_end ? IDLE : WAIT_END;
                end else if (env_end) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!trans && (ivl_q > FULL_MAX_C)) begin
                    err_d   = 1'b1;
                    state_d = WAIT_END;
                end
            end
            WAIT_END: begin
                if (env_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state_q   <= IDLE;
            d_prev_q  <= 1'b0;
            e_prev_q  <= 1'b0;
            ts_cap_q  <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            half_q    <= 1'b0;
            ivl_q     <= '0;
            dout_q    <= '0;
            ts_out_q  <= '0;
            avail_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_prev_q  <= d_in_r;
            e_prev_q  <= e_in_r;
            ts_cap_q  <= ts_cap_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            half_q    <= half_d;
            ivl_q     <= ivl_d;
            dout_q    <= dout_d;
            ts_out_q  <= ts_out_d;
            avail_q   <= avail_d;
            err_q     <= err_d;
        end
    end

    assign data_availible      = avail_q;
    assign decode_error        = err_q;
    assign decoded_data        = dout_q;
    assign timestamp_last_data = ts_out_q;

endmodule
